// File: rtl/bp_update_scheduler.sv
// Branch predictor table write scheduler: init/flush sweep plus an in-order update FIFO.
// Optional stall counter enabled by defining BP_STALL_CNT_EN.
module bp_update_scheduler #(
   parameter int HISTORY_WIDTH = 8,
   parameter int INDEX_WIDTH   = 6,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          flush_req_i,
   input  logic                          cm_valid_i,
   output logic                          cm_ready_o,
   input  logic [HISTORY_WIDTH-1:0]      cm_pht_index_i,
   input  logic                          cm_taken_i,
   input  logic                          cm_btb_wr_i,
   input  logic [INDEX_WIDTH-1:0]        cm_btb_index_i,
   input  logic [32-INDEX_WIDTH-2-1:0]   cm_btb_tag_i,
   input  logic [31:0]                   cm_btb_target_i,
   input  logic                          wr_block_i,
   output logic                          pht_we_o,
   output logic [HISTORY_WIDTH-1:0]      pht_windex_o,
   output logic                          pht_wtaken_o,
   output logic                          pht_init_o,
   output logic                          btb_we_o,
   output logic [INDEX_WIDTH-1:0]        btb_windex_o,
   output logic [32-INDEX_WIDTH-2-1:0]   btb_wtag_o,
   output logic [31:0]                   btb_wtarget_o,
   output logic                          btb_wvalid_o,
   output logic                          pred_en_o,
   output logic [15:0]                   stall_cnt_o
);

   localparam int TAG_WIDTH   = 32 - INDEX_WIDTH - 2;
   localparam int SWEEP_WIDTH = (HISTORY_WIDTH > INDEX_WIDTH) ? HISTORY_WIDTH : INDEX_WIDTH;
   localparam int PTR_WIDTH   = $clog2(FIFO_DEPTH);
   localparam int CNT_WIDTH   = PTR_WIDTH + 1;

   typedef enum logic [0:0] {
      SWEEP = 1'b0,
      RUN   = 1'b1
   } state_t;

   typedef struct packed {
      logic [HISTORY_WIDTH-1:0] pht_index;
      logic                     taken;
      logic                     btb_wr;
      logic [INDEX_WIDTH-1:0]   btb_index;
      logic [TAG_WIDTH-1:0]     btb_tag;
      logic [31:0]              btb_target;
   } entry_t;

   state_t                 state;
   logic [SWEEP_WIDTH-1:0] sweep_idx;
   entry_t                 fifo_mem [FIFO_DEPTH];
   logic [PTR_WIDTH-1:0]   rd_ptr;
   logic [PTR_WIDTH-1:0]   wr_ptr;
   logic [CNT_WIDTH-1:0]   count;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   push;
   logic                   pop;
   logic                   sweep_wr;
   logic                   sweep_last;
   logic                   sweep_pht;
   logic                   sweep_btb;
   entry_t                 in_entry;
   entry_t                 head;

   assign fifo_full  = (count == CNT_WIDTH'(FIFO_DEPTH));
   assign fifo_empty = (count == '0);
   assign cm_ready_o = (state == RUN) && !fifo_full;
   assign pred_en_o  = (state == RUN);

   // Flush and reset swallow any handshake or drain in the same cycle.
   assign push     = cm_valid_i && cm_ready_o && !flush_req_i && !rst_i;
   assign pop      = (state == RUN) && !fifo_empty && !wr_block_i && !flush_req_i && !rst_i;
   assign sweep_wr = (state == SWEEP) && !wr_block_i && !flush_req_i && !rst_i;

   assign sweep_last = (sweep_idx == '1);
   assign sweep_pht  = ((sweep_idx >> HISTORY_WIDTH) == '0);
   assign sweep_btb  = ((sweep_idx >> INDEX_WIDTH) == '0);

   assign in_entry = '{
      pht_index:  cm_pht_index_i,
      taken:      cm_taken_i,
      btb_wr:     cm_btb_wr_i,
      btb_index:  cm_btb_index_i,
      btb_tag:    cm_btb_tag_i,
      btb_target: cm_btb_target_i
   };
   assign head = fifo_mem[rd_ptr];

   // FSM, sweep index and FIFO bookkeeping.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= SWEEP;
         sweep_idx <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
      end else if (flush_req_i) begin
         state     <= SWEEP;
         sweep_idx <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
      end else begin
         case (state)
            SWEEP: begin
               if (sweep_wr) begin
                  sweep_idx <= sweep_idx + SWEEP_WIDTH'(1);
                  if (sweep_last) begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               if (push) begin
                  wr_ptr <= wr_ptr + PTR_WIDTH'(1);
               end
               if (pop) begin
                  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
               end
               case ({push, pop})
                  2'b10:   count <= count + CNT_WIDTH'(1);
                  2'b01:   count <= count - CNT_WIDTH'(1);
                  default: count <= count;
               endcase
            end
            default: begin
               state     <= SWEEP;
               sweep_idx <= '0;
            end
         endcase
      end
   end

   // FIFO payload storage; needs no reset since occupancy gates every read.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_mem[wr_ptr] <= in_entry;
      end
   end

   // Table write port: sweep init writes, or the FIFO head while it drains.
   always_comb begin
      pht_we_o      = 1'b0;
      pht_windex_o  = '0;
      pht_wtaken_o  = 1'b0;
      pht_init_o    = 1'b0;
      btb_we_o      = 1'b0;
      btb_windex_o  = '0;
      btb_wtag_o    = '0;
      btb_wtarget_o = 32'h0;
      btb_wvalid_o  = 1'b0;
      if (sweep_wr) begin
         if (sweep_pht) begin
            pht_we_o     = 1'b1;
            pht_init_o   = 1'b1;
            pht_windex_o = sweep_idx[HISTORY_WIDTH-1:0];
         end else begin
            pht_we_o = 1'b0;
         end
         if (sweep_btb) begin
            btb_we_o     = 1'b1;
            btb_wvalid_o = 1'b0;
            btb_windex_o = sweep_idx[INDEX_WIDTH-1:0];
         end else begin
            btb_we_o = 1'b0;
         end
      end else if (pop) begin
         pht_we_o      = 1'b1;
         pht_windex_o  = head.pht_index;
         pht_wtaken_o  = head.taken;
         btb_we_o      = head.btb_wr;
         btb_wvalid_o  = 1'b1;
         btb_windex_o  = head.btb_index;
         btb_wtag_o    = head.btb_tag;
         btb_wtarget_o = head.btb_target;
      end else begin
         pht_we_o = 1'b0;
      end
   end

`ifdef BP_STALL_CNT_EN
   logic [15:0] stall_cnt;

   // Saturating count of cycles where commit offers an update that is refused.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt <= 16'h0000;
      end else if (cm_valid_i && !cm_ready_o && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'h0001;
      end else begin
         stall_cnt <= stall_cnt;
      end
   end

   assign stall_cnt_o = stall_cnt;
`else
   assign stall_cnt_o = 16'h0000;
`endif

endmodule
